// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types and constants for the SPI master driver
package spi_master_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        RECV  = 3'd4,
        END   = 3'd5
    } state_e;

endpackage

// File: rtl/spi_master_driver.sv
// rtl/spi_master_driver.sv - SPI master serialising 10-bit commands and capturing read replies
module spi_master_driver
    import spi_master_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [FRAME_W-1:0] req_din,
    output logic               req_ready,
    output logic               MOSI,
    output logic               SS_n,
    input  logic               MISO,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               is_rd_q, is_rd_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  cap_q, cap_d;

    logic               ss_n_q, ss_n_d;
    logic               mosi_q, mosi_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
    logic               req_ready_q, req_ready_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // bit_cnt walks the frame bits in SHIFT and the reply bits in RECV; cnt times WAIT and END
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        is_rd_d   = is_rd_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    shift_d = req_din;
                    is_rd_d = (req_din[9:8] == CMD_RD_DATA);
                    state_d = START;
                end
            end
            START: begin
                bit_cnt_d = 4'(FRAME_W - 1);
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_q == 4'd0) begin
                    if (is_rd_q) begin
                        cnt_d   = 4'(RD_LAT - 1);
                        state_d = WAIT;
                    end else begin
                        cnt_d   = 4'(GAP - 1);
                        state_d = END;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    bit_cnt_d = 4'(DATA_W - 1);
                    state_d   = RECV;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECV: begin
                cap_d = {cap_q[DATA_W-2:0], MISO};
                if (bit_cnt_q == 4'd0) begin
                    cnt_d   = 4'(GAP - 1);
                    state_d = END;
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            END: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered pins line up with the state they describe
    always_comb begin
        ss_n_d      = !(state_d == START || state_d == SHIFT || state_d == WAIT || state_d == RECV);
        mosi_d      = 1'b0;
        if (state_d == START) begin
            mosi_d = shift_d[FRAME_W-1];
        end else if (state_d == SHIFT) begin
            mosi_d = shift_d[bit_cnt_d];
        end
        rsp_valid_d = (state_q == RECV) && (state_d == END);
        rsp_data_d  = rsp_valid_d ? cap_d : rsp_data_q;
        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            is_rd_q     <= 1'b0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            shift_q     <= shift_d;
            is_rd_q     <= is_rd_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_spi_master_driver.sv
// tb/tb_spi_master_driver.sv - self-checking bench for spi_master_driver
module tb_spi_master_driver;

    localparam int RD_LAT = 2;
    localparam int GAP    = 1;
    localparam logic [4:0] IDLE_PINS = 5'b10001;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [9:0] req_din;
    logic       req_ready;
    logic       MOSI;
    logic       SS_n;
    logic       MISO;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    spi_master_driver #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_din   (req_din),
        .req_ready (req_ready),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .MISO      (MISO),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the first SS_n-low cycle; pins {SS_n,MOSI,rsp_valid,busy,req_ready} follow from frame length alone
    task automatic run_frame(input logic [9:0] din, input logic [7:0] rbyte, input bit chain,
                             input logic [9:0] next_din, input int poke_c, input int abort_c);
        bit         is_rd = (din[9:8] == 2'b11);
        int         flen  = is_rd ? (19 + RD_LAT) : 11;
        logic       mosi_exp;
        logic [4:0] exp;
        chk($sformatf("ready_before_%03h", din), req_ready, 1);
        req_valid = 1'b1;
        req_din   = din;
        @(posedge clk);
        @(negedge clk);
        if (chain) req_din = next_din;
        else       req_valid = 1'b0;
        for (int c = 0; c <= flen + GAP; c++) begin
            if (c > 0) @(negedge clk);
            if (is_rd && c >= 11 + RD_LAT && c <= 18 + RD_LAT) MISO = rbyte[18 + RD_LAT - c];
            else                                               MISO = 1'($urandom % 2);
            if (c == 0)       mosi_exp = din[9];
            else if (c <= 10) mosi_exp = din[10 - c];
            else              mosi_exp = 1'b0;
            exp = {c >= flen, mosi_exp, is_rd && c == flen, c < flen + GAP, c >= flen + GAP};
            chk($sformatf("frame_%03h_c%0d_pins", din, c), {SS_n, MOSI, rsp_valid, busy, req_ready}, exp);
            if (is_rd && c == flen) chk($sformatf("frame_%03h_rsp_data", din), rsp_data, rbyte);
            if (c == poke_c) begin
                req_valid = 1'b1;
                req_din   = ~din;
            end else if (c == poke_c + 1) begin
                req_valid = 1'b0;
            end
            if (c == abort_c) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_pins", {SS_n, MOSI, rsp_valid, busy, req_ready}, IDLE_PINS);
                chk("abort_rsp_data", rsp_data, 0);
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 25; k++) begin
                    @(negedge clk);
                    MISO = 1'($urandom % 2);
                    chk($sformatf("post_abort_k%0d", k), {SS_n, MOSI, rsp_valid, busy, req_ready}, IDLE_PINS);
                end
                return;
            end
        end
    endtask

    initial begin
        logic [9:0] cur;
        logic [9:0] nxt;
        logic [7:0] rb;
        bit         ch;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_din   = '0;
        MISO      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_pins", {SS_n, MOSI, rsp_valid, busy, req_ready}, IDLE_PINS);
        chk("reset_rsp_data", rsp_data, 0);

        run_frame(10'b00_1010_0101, 8'h00, 1'b0, 10'h000, -1, -1);
        run_frame(10'b11_0000_0000, 8'h3C, 1'b0, 10'h000, -1, -1);
        run_frame(10'b00_1010_0101, 8'h00, 1'b1, 10'h155, -1, -1);
        run_frame(10'h155,          8'h00, 1'b0, 10'h000, -1, -1);
        run_frame(10'h2C3,          8'h00, 1'b0, 10'h000, 4, -1);
        run_frame(10'h3FF,          8'hA7, 1'b0, 10'h000, -1, -1);
        run_frame(10'h300,          8'h5A, 1'b0, 10'h000, -1, 6);
        run_frame(10'h300,          8'hC3, 1'b0, 10'h000, -1, -1);

        cur = 10'($urandom);
        for (int i = 0; i < 24; i++) begin
            nxt = 10'($urandom);
            rb  = 8'($urandom);
            ch  = (i != 23) && ($urandom % 2 == 1);
            run_frame(cur, rb, ch, nxt, -1, -1);
            if (!ch) repeat ($urandom % 3) @(negedge clk);
            cur = nxt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_driver.md
Name: spi_master_driver

Overview:
- Synthesisable SPI master that sits directly upstream of the SPI wrapper (SPI slave plus RAM).
- Accepts 10-bit command words over a valid/ready request port.
- Serialises each command onto MOSI, with SS_n framing, in the same clock domain as the slave.
- For read-data commands, captures the 8-bit reply shifted back on MISO and returns it on a response port.
- Used as the stimulus front-end for system-level and FPGA bring-up of the wrapper.

Parameters:
- RD_LAT, default 2: idle cycles after the last MOSI bit of a read-data frame before MISO bit 7 is sampled. Range 1-15.
- GAP, default 1: cycles SS_n is held high after a frame before the next request is accepted. Range 1-15.

Ports:
- clk  in  1  system clock; slave samples MOSI on the same edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  command word available.
- req_din  in  10  command word; [9:8] = cmd, [7:0] = address or data.
- req_ready  out  1  high in IDLE only; the transfer starts on req_valid && req_ready.
- MOSI  out  1  serial data to slave.
- SS_n  out  1  slave select, active-low.
- MISO  in  1  serial data from slave.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  8  captured read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Command encoding on req_din[9:8]:
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read data
- Reset (synchronous, rst=1 at the edge):
  - Next state IDLE.
  - SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0x00, busy=0.
  - Applies mid-frame: SS_n rises on the same edge and the partial frame is discarded.
  - No rsp_valid is generated for a frame interrupted by reset.
- All outputs are registered.
- States: IDLE, START, SHIFT, WAIT, RECV, END.
- IDLE:
  - req_ready=1, SS_n=1.
  - On accept, latch req_din into a 10-bit shift register and latch is_rd = (cmd==11), then go to START.
- START (1 cycle, the slave's command-check cycle):
  - SS_n=0, MOSI=req_din[9].
  - Go to SHIFT with bit_cnt=9.
- SHIFT (10 cycles):
  - MOSI = shift register bit [bit_cnt], MSB first (din[9] down to din[0]).
  - Decrement bit_cnt.
  - After bit 0: go to WAIT if is_rd, else END.
- WAIT (RD_LAT cycles): SS_n=0, MOSI=0, with a down-counter.
- RECV (8 cycles):
  - Sample MISO each cycle into the capture register, MSB first.
  - After 8 samples, rsp_data <= captured byte and go to END.
- END (GAP cycles):
  - SS_n=1, MOSI=0.
  - rsp_valid=1 in the first END cycle, only for read-data frames.
  - Then go to IDLE.
- Frame lengths (SS_n low):
  - Non-read-data frame: 11 cycles.
  - Read-data frame: 11+RD_LAT+8 cycles.
- Request handling:
  - req_din changes while busy are ignored; the latched copy is used.
  - A request is accepted only in IDLE; there is no queue. The requester must hold req_valid until it sees req_ready.
- Back-to-back: a request valid throughout is accepted on the first IDLE cycle after END, giving SS_n high for exactly GAP+1 cycles between frames.
- Misuse: a read-data without a preceding read-address is still issued; returning data in that case is the slave's concern.

Decomposition:
- Shared package spi_master_pkg:
  - state enum (IDLE, START, SHIFT, WAIT, RECV, END), 3 bits.
  - cmd constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FRAME_W=10, DATA_W=8.
- No sub-module is required. Shift register, bit counter and wait counter live in the single module.

Test Plan:
- Reset: assert rst for 2 cycles, with and without an active frame -> SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0x00, busy=0, req_ready=1 on the cycle after release.
- Write address: req_din=10'b00_1010_0101 -> SS_n low for 11 cycles; MOSI sequence 0,0,0,1,0,1,0,0,1,0,1; no rsp_valid; busy drops after GAP.
- Read data: req_din=10'b11_0000_0000; bench drives MISO=0x3C MSB-first starting RD_LAT=2 cycles after the last MOSI bit -> rsp_valid pulses exactly once; rsp_data=0x3C; SS_n low for 21 cycles.
- Back-to-back: write-address then write-data (0x1_55), req_valid held high -> second frame starts with SS_n high exactly 2 cycles between frames; both MOSI sequences correct.
- Request while busy: pulse req_valid with a different req_din during SHIFT -> ignored, req_ready=0; the original frame is unaltered.
- Mid-frame reset: assert rst at SHIFT bit 4 of a read-data frame -> SS_n=1 on the next edge, no rsp_valid, and the next request completes normally.
